// File: rtl/idli_pkg.sv
// Shared fetch-side types: fetch FSM states, SQI nibble type, read command default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Config macro IDLI_FETCH_SQI_DUMMY_EN: adds the DUMMY state and its cycle count.
package idli_pkg;

  // One SQI bus nibble; also the unit handed to decode.
  typedef logic [3:0] sqi_data_t;

  // Default SQI "read" opcode.
  localparam logic [7:0] SQI_CMD_READ_DFLT = 8'h03;

  // Cycles spent in each serial phase (one nibble per cycle).
  localparam logic [2:0] CMD_NIBS  = 3'd2;
  localparam logic [2:0] ADDR_NIBS = 3'd6;
`ifdef IDLI_FETCH_SQI_DUMMY_EN
  localparam logic [2:0] DUMMY_CYCLES = 3'd2;
`endif

  typedef enum logic [2:0] {
    FCH_IDLE,
    FCH_CMD,
    FCH_ADDR,
`ifdef IDLI_FETCH_SQI_DUMMY_EN
    FCH_DUMMY,
`endif
    FCH_DATA
  } fch_state_t;

  // Instructions are 16b words; the memory is byte addressed with 24b addresses.
  function automatic logic [23:0] pc_to_byte_addr(input logic [15:0] pc);
    return {7'b0, pc, 1'b0};
  endfunction

endpackage

// File: rtl/idli_sqi_ser_m.sv
// SQI command/address serialiser: loads {cmd, addr} and shifts out one nibble per cycle, MSB first.
// Latency: first nibble (cmd[7:4]) appears the cycle after ld_vld.
// Backpressure: none; shifts every cycle it is not loading.
//
// Ports: i_fch_gck clock, i_dcd_rst_n async active-low reset,
//        ld_vld load strobe, cmd_dat 8b command, addr_dat 24b byte address,
//        nib_dat current nibble to drive onto the SQI bus.
module idli_sqi_ser_m
  import idli_pkg::*;
(
  input  logic        i_fch_gck,
  input  logic        i_dcd_rst_n,
  input  logic        ld_vld,
  input  logic [7:0]  cmd_dat,
  input  logic [23:0] addr_dat,
  output sqi_data_t   nib_dat
);

  logic [31:0] sh_q;

  always_ff @(posedge i_fch_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      sh_q <= '0;
    end else if (ld_vld) begin
      sh_q <= {cmd_dat, addr_dat};
    end else begin
      sh_q <= {sh_q[27:0], 4'h0};
    end
  end

  assign nib_dat = sh_q[31:28];

endmodule

// File: rtl/idli_fetch_m.sv
// Instruction fetch over SQI: issues a read at pc, then streams instruction nibbles to decode.
// Latency: memory nibble -> o_dcd_enc one cycle; first valid nibble 12 clocks after reset (10 without dummy).
// Backpressure: none; decode must accept one nibble per cycle, redirect is the only flow control.
//
// Ports: i_fch_gck clock, i_dcd_rst_n async active-low reset,
//        i_fch_redirect / i_fch_redirect_pc restart fetch at a new word address,
//        o_fch_sqi_cs_n / o_fch_sqi_out / o_fch_sqi_oe / i_fch_sqi_in SQI memory pins,
//        o_dcd_enc / o_dcd_enc_vld nibble stream to decode, o_fch_pc word address of that stream.
// Config macro IDLI_FETCH_SQI_DUMMY_EN: inserts two dummy cycles between address and data.
module idli_fetch_m
  import idli_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [7:0]  SQI_CMD_READ = SQI_CMD_READ_DFLT
) (
  input  logic        i_fch_gck,
  input  logic        i_dcd_rst_n,
  input  logic        i_fch_redirect,
  input  logic [15:0] i_fch_redirect_pc,
  output logic        o_fch_sqi_cs_n,
  output logic [3:0]  o_fch_sqi_out,
  output logic        o_fch_sqi_oe,
  input  logic [3:0]  i_fch_sqi_in,
  output sqi_data_t   o_dcd_enc,
  output logic        o_dcd_enc_vld,
  output logic [15:0] o_fch_pc
);

  fch_state_t  state_q, state_d;
  logic [2:0]  cyc_q, cyc_d;      // cycles spent in the current serial phase
  logic [15:0] pc_q;
  logic [1:0]  nib_q;             // index of the delivered nibble within its instruction
  sqi_data_t   enc_q;
  logic        vld_q;
  logic        ser_ld;
  sqi_data_t   ser_nib;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge i_fch_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      state_q <= FCH_IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // ------------------------------------------------ FSM next state / outputs
  always_comb begin
    state_d        = state_q;
    cyc_d          = cyc_q + 3'd1;
    o_fch_sqi_cs_n = 1'b0;
    o_fch_sqi_oe   = 1'b0;
    ser_ld         = 1'b0;

    case (state_q)
      FCH_IDLE: begin
        // pc_q is already the target here, so the serialiser loads the right address.
        o_fch_sqi_cs_n = 1'b1;
        ser_ld         = 1'b1;
        state_d        = FCH_CMD;
        cyc_d          = '0;
      end
      FCH_CMD: begin
        o_fch_sqi_oe = 1'b1;
        if (cyc_q == CMD_NIBS - 3'd1) begin
          state_d = FCH_ADDR;
          cyc_d   = '0;
        end
      end
      FCH_ADDR: begin
        o_fch_sqi_oe = 1'b1;
        if (cyc_q == ADDR_NIBS - 3'd1) begin
`ifdef IDLI_FETCH_SQI_DUMMY_EN
          state_d = FCH_DUMMY;
`else
          state_d = FCH_DATA;
`endif
          cyc_d   = '0;
        end
      end
`ifdef IDLI_FETCH_SQI_DUMMY_EN
      FCH_DUMMY: begin
        if (cyc_q == DUMMY_CYCLES - 3'd1) begin
          state_d = FCH_DATA;
          cyc_d   = '0;
        end
      end
`endif
      FCH_DATA: begin
        // Streams sequential words until redirected.
        cyc_d = cyc_q;
      end
      default: begin
        o_fch_sqi_cs_n = 1'b1;
        state_d        = FCH_IDLE;
        cyc_d          = '0;
      end
    endcase

    if (i_fch_redirect) begin
      state_d = FCH_IDLE;
      cyc_d   = '0;
    end
  end

  // ---------------------------------------------------- command/address shift
  idli_sqi_ser_m u_ser (
    .i_fch_gck   (i_fch_gck),
    .i_dcd_rst_n (i_dcd_rst_n),
    .ld_vld      (ser_ld),
    .cmd_dat     (SQI_CMD_READ),
    .addr_dat    (pc_to_byte_addr(pc_q)),
    .nib_dat     (ser_nib)
  );

  assign o_fch_sqi_out = ser_nib;

  // ------------------------------------------------------------ data capture
  always_ff @(posedge i_fch_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      pc_q  <= RESET_PC;
      nib_q <= '0;
      enc_q <= '0;
      vld_q <= 1'b0;
    end else if (i_fch_redirect) begin
      // Any partially delivered instruction is dropped here.
      pc_q  <= i_fch_redirect_pc;
      nib_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= (state_q == FCH_DATA);
      if (state_q == FCH_DATA) begin
        enc_q <= i_fch_sqi_in;
      end
      // pc tracks the instruction on o_dcd_enc, so it advances once its last nibble has been shown.
      if (vld_q) begin
        nib_q <= nib_q + 2'd1;
        if (nib_q == 2'd3) begin
          pc_q <= pc_q + 16'd1;
        end
      end
    end
  end

  assign o_dcd_enc     = enc_q;
  assign o_dcd_enc_vld = vld_q;
  assign o_fch_pc      = pc_q;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Bench for idli_fetch_m: SQI memory responder, transaction-level expectation model, directed + random redirects.
// Latency: n/a.
// Backpressure: n/a.
module tb_idli_fetch_m;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [7:0]  CMD      = 8'h03;
`ifdef IDLI_FETCH_SQI_DUMMY_EN
  localparam int D         = 11;  // cycle index (from IDLE=0) of the first DATA cycle
  localparam int FIRST_VLD = 12;
`else
  localparam int D         = 9;
  localparam int FIRST_VLD = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        cs_n;
  logic [3:0]  sqi_out;
  logic        oe;
  logic [3:0]  sqi_in;
  logic [3:0]  enc;
  logic        enc_vld;
  logic [15:0] fch_pc;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  idli_fetch_m #(.RESET_PC(RESET_PC), .SQI_CMD_READ(CMD)) dut (
    .i_fch_gck         (clk),
    .i_dcd_rst_n       (rst_n),
    .i_fch_redirect    (redirect),
    .i_fch_redirect_pc (redirect_pc),
    .o_fch_sqi_cs_n    (cs_n),
    .o_fch_sqi_out     (sqi_out),
    .o_fch_sqi_oe      (oe),
    .i_fch_sqi_in      (sqi_in),
    .o_dcd_enc         (enc),
    .o_dcd_enc_vld     (enc_vld),
    .o_fch_pc          (fch_pc)
  );

  // ------------------------------------------------------------ memory image
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'(a * 16'h9E37 + 16'hA5C3);
  endfunction

  // Nibble m of a sequential stream that starts at word a, MSB first.
  function automatic logic [3:0] mem_nib(input logic [15:0] a, input int m);
    logic [15:0] w;
    w = mem_word(16'(a + 16'(m / 4)));
    return w[15 - 4 * (m % 4) -: 4];
  endfunction

  // SQI memory responder: decodes the address from the pins and streams data.
  int          mj    = 0;
  logic [23:0] maddr = '0;
  logic [3:0]  noise = '0;

  always @(negedge clk) begin
    mj <= cs_n ? 0 : mj + 1;
    if (!cs_n && (mj + 1) >= 3 && (mj + 1) <= 8) maddr <= {maddr[19:0], sqi_out};
    noise <= 4'($urandom);
  end

  assign sqi_in = (mj >= D) ? mem_nib(maddr[16:1], mj - D) : noise;

  // -------------------------------------------------------- expectation model
  // k = cycles since the transaction started (IDLE is 0); P = word address fetched.
  int          k = 0;
  logic [15:0] P = RESET_PC;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      P <= RESET_PC;
    end else if (redirect) begin
      k <= 0;
      P <= redirect_pc;
    end else if (k < 1000000) begin
      k <= k + 1;
    end
  end

  function automatic logic exp_cs_n(input int kk);
    return kk == 0;
  endfunction

  function automatic logic exp_oe(input int kk);
    return kk >= 1 && kk <= 8;
  endfunction

  function automatic logic [3:0] exp_out(input int kk, input logic [15:0] p);
    logic [31:0] s;
    s = {CMD, 7'b0, p, 1'b0};
    return s[31 - 4 * (kk - 1) -: 4];
  endfunction

  function automatic logic exp_vld(input int kk);
    return kk >= D + 1;
  endfunction

  function automatic logic [15:0] exp_pc(input int kk, input logic [15:0] p);
    if (kk >= D + 1) return 16'(p + 16'((kk - D - 1) / 4));
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cs_n", 32'(cs_n), 32'(exp_cs_n(k)));
    chk("oe", 32'(oe), 32'(exp_oe(k)));
    if (exp_oe(k)) chk("sqi_out", 32'(sqi_out), 32'(exp_out(k, P)));
    chk("enc_vld", 32'(enc_vld), 32'(exp_vld(k)));
    if (exp_vld(k)) chk("enc", 32'(enc), 32'(mem_nib(P, k - D - 1)));
    chk("pc", 32'(fch_pc), 32'(exp_pc(k, P)));
  end

  // ------------------------------------------------------------ directed part
  logic [3:0] seen[$];

  task automatic wait_vld(input string name);
    int cyc;
    cyc = 0;
    seen.delete();
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (oe) seen.push_back(sqi_out);
      if (enc_vld) break;
    end
    chk(name, 32'(cyc), 32'(FIRST_VLD));
  endtask

  task automatic chk_seen(input string name, input logic [31:0] exp);
    chk(name, 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk(name, 32'(seen[i]), 32'(exp[31 - 4 * i -: 4]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp4 [4];
    int r;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_enc", 32'(enc), 32'd0);
    chk("rst_vld", 32'(enc_vld), 32'd0);
    chk("rst_pc", 32'(fch_pc), 32'(RESET_PC));
    rst_n = 1'b1;

    // First read from word 0 after reset.
    wait_vld("first_vld_latency");
    chk_seen("reset_cmd_addr", 32'h0300_0000);
    exp4 = '{4'hA, 4'h5, 4'hC, 4'h3};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("w0_vld", 32'(enc_vld), 32'd1);
      chk("w0_enc", 32'(enc), 32'(exp4[i]));
      chk("w0_pc", 32'(fch_pc), 32'd0);
    end
    for (int i = 4; i < 12; i++) begin
      step();
      chk("stream_vld", 32'(enc_vld), 32'd1);
      chk("stream_pc", 32'(fch_pc), 32'(i / 4));
    end

    // Redirect two nibbles into word 3.
    step();
    step();
    chk("pre_redir_vld", 32'(enc_vld), 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h1234;
    step();
    redirect = 1'b0;
    chk("redir_vld_drop", 32'(enc_vld), 32'd0);
    chk("redir_cs_n", 32'(cs_n), 32'd1);
    wait_vld("redir_vld_latency");
    chk_seen("redir_cmd_addr", 32'h0300_2468);
    exp4 = '{4'hA, 4'h6, 4'hE, 4'hF};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("w1234_enc", 32'(enc), 32'(exp4[i]));
      chk("w1234_pc", 32'(fch_pc), 32'h1234);
    end

    // pc wrap at the top of the address space.
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    wait_vld("wrap_vld_latency");
    exp4 = '{4'h0, 4'h7, 4'h8, 4'hC};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("wffff_enc", 32'(enc), 32'(exp4[i]));
      chk("wffff_pc", 32'(fch_pc), 32'hFFFF);
    end
    step();
    chk("wrap_pc", 32'(fch_pc), 32'h0000);
    chk("wrap_vld", 32'(enc_vld), 32'd1);

    // Back-to-back redirects: the later target is the one fetched.
    redirect = 1'b1;
    redirect_pc = 16'h1111;
    step();
    redirect_pc = 16'h2222;
    step();
    redirect = 1'b0;
    chk("b2b_pc_idle", 32'(fch_pc), 32'h2222);
    chk("b2b_cs_n", 32'(cs_n), 32'd1);
    wait_vld("b2b_vld_latency");
    chk_seen("b2b_cmd_addr", 32'h0300_4444);
    chk("b2b_pc", 32'(fch_pc), 32'h2222);

    // Asynchronous reset in the middle of the address phase.
    redirect = 1'b1;
    redirect_pc = 16'h4321;
    step();
    redirect = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_oe", 32'(oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 32'(cs_n), 32'd1);
    chk("arst_oe", 32'(oe), 32'd0);
    chk("arst_vld", 32'(enc_vld), 32'd0);
    chk("arst_enc", 32'(enc), 32'd0);
    chk("arst_pc", 32'(fch_pc), 32'(RESET_PC));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_vld("rerst_vld_latency");
    chk_seen("rerst_cmd_addr", 32'h0300_0000);
    chk("rerst_enc", 32'(enc), 32'hA);

    // Random redirects and occasional resets, checked every cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      step();
      r = $urandom_range(0, 999);
      if (r < 30) begin
        redirect = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                   : 16'($urandom);
      end else begin
        redirect = 1'b0;
      end
      if (r >= 997) begin
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    redirect = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
